// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control blocks: FSM state, default widths,
// and the hard-wired zero register specifier.
package pipe_ctrl_pkg;
    localparam int REG_W_DEF  = 5;
    localparam int ADDR_W_DEF = 32;

    localparam logic [REG_W_DEF-1:0] REG_ZERO = '0;

    typedef enum logic {
        RUN,
        LU_STALL
    } luState_t;
endpackage

// File: rtl/fetch_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);
    always_ff @(posedge clk) begin
        if (clear)
            cnt <= '0;
        else if (inc && (cnt != {CNT_W{1'b1}}))
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/fetch_hazard_ctrl.sv
// Fetch-stage sequencer: load-use hazard stalls, external freeze, gated branch
// redirects and saturating stall/flush performance counters.
module fetch_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W             = REG_W_DEF,
    parameter int ADDR_W            = ADDR_W_DEF,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_W-1:0]  idRs,
    input  logic [REG_W-1:0]  idRt,
    input  logic              idUsesRt,
    input  logic              exMemRead,
    input  logic [REG_W-1:0]  exRt,
    input  logic              branchTaken,
    input  logic [ADDR_W-1:0] branchTarget,
    input  logic              extStall,
    output logic              stall,
    output logic              branchResult,
    output logic [ADDR_W-1:0] branchAddrs,
    output logic              idBubble,
    output logic [CNT_W-1:0]  stallCycles,
    output logic [CNT_W-1:0]  flushCount
);
    luState_t   state;
    logic [3:0] luCnt;
    logic       loadUse;

    // $zero is never a real producer, so a load targeting it cannot create a hazard.
    assign loadUse = exMemRead && (exRt != REG_W'(REG_ZERO)) &&
                     ((exRt == idRs) || (idUsesRt && (exRt == idRt)));

    always_comb begin
        stall        = 1'b0;
        branchResult = 1'b0;
        branchAddrs  = '0;
        idBubble     = 1'b0;
        if (reset) begin
            idBubble = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (extStall) begin
                        stall = 1'b1;
                    end else if (loadUse) begin
                        stall    = 1'b1;
                        idBubble = 1'b1;
                    end else if (branchTaken) begin
                        branchResult = 1'b1;
                        branchAddrs  = branchTarget;
                    end
                end
                LU_STALL: begin
                    stall    = 1'b1;
                    idBubble = !extStall;
                end
                default: ;
            endcase
        end
    end

    // ID is frozen during LU_STALL, so only the countdown decides when to leave.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            luCnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (!extStall && loadUse && (LOAD_STALL_CYCLES > 1)) begin
                        state <= LU_STALL;
                        luCnt <= 4'(LOAD_STALL_CYCLES - 1);
                    end
                end
                LU_STALL: begin
                    if (!extStall) begin
                        luCnt <= luCnt - 4'd1;
                        if (luCnt == 4'd1)
                            state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    sat_counter #(.CNT_W(CNT_W)) uStallCnt (
        .clk   (clk),
        .clear (reset),
        .inc   (stall),
        .cnt   (stallCycles)
    );

    sat_counter #(.CNT_W(CNT_W)) uFlushCnt (
        .clk   (clk),
        .clear (reset),
        .inc   (branchResult),
        .cnt   (flushCount)
    );
endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// Directed bench: single-cycle vector table on a 1-bubble instance, hand sequences
// on a 3-bubble instance and a 4-bit counter instance.
module tb_fetch_hazard_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  idRs, idRt, exRt;
    logic        idUsesRt, exMemRead, branchTaken, extStall;
    logic [31:0] branchTarget;

    logic        aStall, aBr, aBub, bStall, bBr, bBub, cStall, cBr, cBub;
    logic [31:0] aAddr, bAddr, cAddr;
    logic [15:0] aStallCnt, aFlushCnt, bStallCnt, bFlushCnt;
    logic [3:0]  cStallCnt, cFlushCnt;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    fetch_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(16)) dutA (
        .clk(clk), .reset(reset), .idRs(idRs), .idRt(idRt), .idUsesRt(idUsesRt),
        .exMemRead(exMemRead), .exRt(exRt), .branchTaken(branchTaken),
        .branchTarget(branchTarget), .extStall(extStall), .stall(aStall),
        .branchResult(aBr), .branchAddrs(aAddr), .idBubble(aBub),
        .stallCycles(aStallCnt), .flushCount(aFlushCnt));

    fetch_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(16)) dutB (
        .clk(clk), .reset(reset), .idRs(idRs), .idRt(idRt), .idUsesRt(idUsesRt),
        .exMemRead(exMemRead), .exRt(exRt), .branchTaken(branchTaken),
        .branchTarget(branchTarget), .extStall(extStall), .stall(bStall),
        .branchResult(bBr), .branchAddrs(bAddr), .idBubble(bBub),
        .stallCycles(bStallCnt), .flushCount(bFlushCnt));

    fetch_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(4)) dutC (
        .clk(clk), .reset(reset), .idRs(idRs), .idRt(idRt), .idUsesRt(idUsesRt),
        .exMemRead(exMemRead), .exRt(exRt), .branchTaken(branchTaken),
        .branchTarget(branchTarget), .extStall(extStall), .stall(cStall),
        .branchResult(cBr), .branchAddrs(cAddr), .idBubble(cBub),
        .stallCycles(cStallCnt), .flushCount(cFlushCnt));

    typedef struct {
        logic [4:0]  rs, rt, ert;
        logic        usesRt, memRd, brT, ext;
        logic [31:0] tgt;
        logic        eStall, eBr, eBub;
        logic [31:0] eAddr;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearIn();
        idRs = 0; idRt = 0; exRt = 0; idUsesRt = 0; exMemRead = 0;
        branchTaken = 0; extStall = 0; branchTarget = 0;
    endtask

    task automatic doReset();
        clearIn();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic chkB(input string name, input logic s, input logic br, input logic bub,
                        input logic [31:0] addr);
        chk({name, ".stall"}, 32'(bStall), 32'(s));
        chk({name, ".br"}, 32'(bBr), 32'(br));
        chk({name, ".bubble"}, 32'(bBub), 32'(bub));
        chk({name, ".addr"}, bAddr, addr);
    endtask

    task automatic hazard();
        exMemRead = 1; exRt = 5'd8; idRs = 5'd8;
    endtask

    initial begin
        //           rs  rt  ert uRt mRd brT ext tgt            stall br  bub addr
        tbl[0]  = '{ 0,  0,  0,  0,  0,  0,  0,  32'h0,         0,    0,  0,  32'h0 };
        tbl[1]  = '{ 8,  0,  8,  0,  1,  0,  0,  32'h0,         1,    0,  1,  32'h0 };
        tbl[2]  = '{ 8,  0,  8,  0,  0,  0,  0,  32'h0,         0,    0,  0,  32'h0 };
        tbl[3]  = '{ 0,  0,  0,  1,  1,  0,  0,  32'h0,         0,    0,  0,  32'h0 };
        tbl[4]  = '{ 1,  9,  9,  0,  1,  0,  0,  32'h0,         0,    0,  0,  32'h0 };
        tbl[5]  = '{ 1,  9,  9,  1,  1,  0,  0,  32'h0,         1,    0,  1,  32'h0 };
        tbl[6]  = '{ 2,  3,  4,  1,  1,  1,  0,  32'h100,       0,    1,  0,  32'h100 };
        tbl[7]  = '{ 5,  0,  5,  0,  1,  1,  0,  32'h200,       1,    0,  1,  32'h0 };
        tbl[8]  = '{ 0,  0,  0,  0,  0,  1,  1,  32'h300,       1,    0,  0,  32'h0 };
        tbl[9]  = '{ 5,  0,  5,  0,  1,  0,  1,  32'h0,         1,    0,  0,  32'h0 };
        tbl[10] = '{ 0,  0,  0,  0,  0,  1,  0,  32'hdeadbeef,  0,    1,  0,  32'hdeadbeef };
        tbl[11] = '{ 31, 0,  31, 0,  1,  0,  0,  32'h0,         1,    0,  1,  32'h0 };

        clearIn();
        reset = 1'b1;
        #1;
        chk("rst.stall", 32'(aStall), 32'd0);
        chk("rst.br", 32'(aBr), 32'd0);
        chk("rst.bubble", 32'(aBub), 32'd1);
        chk("rst.addr", aAddr, 32'd0);
        tick();
        chk("rst.stallCnt", 32'(aStallCnt), 32'd0);
        chk("rst.flushCnt", 32'(aFlushCnt), 32'd0);
        reset = 1'b0;

        // Single-bubble instance never leaves RUN, so each vector is independent.
        for (int i = 0; i < 12; i++) begin
            idRs = tbl[i].rs; idRt = tbl[i].rt; exRt = tbl[i].ert;
            idUsesRt = tbl[i].usesRt; exMemRead = tbl[i].memRd;
            branchTaken = tbl[i].brT; extStall = tbl[i].ext; branchTarget = tbl[i].tgt;
            #1;
            chk($sformatf("vec%0d.stall", i), 32'(aStall), 32'(tbl[i].eStall));
            chk($sformatf("vec%0d.br", i), 32'(aBr), 32'(tbl[i].eBr));
            chk($sformatf("vec%0d.bubble", i), 32'(aBub), 32'(tbl[i].eBub));
            chk($sformatf("vec%0d.addr", i), aAddr, tbl[i].eAddr);
            tick();
        end
        clearIn();
        #1;
        chk("tbl.stallCnt", 32'(aStallCnt), 32'd6);
        chk("tbl.flushCnt", 32'(aFlushCnt), 32'd2);
        chk("tbl.idle", 32'(aStall), 32'd0);

        // Branch held off across a 3-cycle load-use stall.
        doReset();
        hazard(); branchTaken = 1; branchTarget = 32'h40;
        #1; chkB("brHold.c1", 1, 0, 1, 0);
        tick();
        exMemRead = 0; exRt = 0; idRs = 0;
        chkB("brHold.c2", 1, 0, 1, 0);
        tick(); chkB("brHold.c3", 1, 0, 1, 0);
        tick(); chkB("brHold.c4", 0, 1, 0, 32'h40);
        tick();
        branchTaken = 0; #1;
        chk("brHold.flushCnt", 32'(bFlushCnt), 32'd1);
        chk("brHold.stallCnt", 32'(bStallCnt), 32'd3);

        // External freeze pauses the load-use countdown.
        doReset();
        hazard();
        #1; chkB("frz.c1", 1, 0, 1, 0);
        tick(); clearIn(); chkB("frz.c2", 1, 0, 1, 0);
        tick(); extStall = 1; #1; chkB("frz.c3", 1, 0, 0, 0);
        tick(); chkB("frz.c4", 1, 0, 0, 0);
        tick(); extStall = 0; #1; chkB("frz.c5", 1, 0, 1, 0);
        tick(); chkB("frz.c6", 0, 0, 0, 0);
        chk("frz.stallCnt", 32'(bStallCnt), 32'd5);

        // Reset in the middle of LU_STALL.
        doReset();
        hazard();
        tick(); clearIn();
        reset = 1; #1;
        chkB("rstMid.during", 0, 0, 1, 0);
        tick(); reset = 0; #1;
        chkB("rstMid.after", 0, 0, 0, 0);
        chk("rstMid.stallCnt", 32'(bStallCnt), 32'd0);
        chk("rstMid.flushCnt", 32'(bFlushCnt), 32'd0);
        hazard();
        #1; chkB("rstMid.h1", 1, 0, 1, 0);
        tick(); clearIn(); chkB("rstMid.h2", 1, 0, 1, 0);
        tick(); chkB("rstMid.h3", 1, 0, 1, 0);
        tick(); chkB("rstMid.h4", 0, 0, 0, 0);
        chk("rstMid.stallCnt2", 32'(bStallCnt), 32'd3);

        // 4-bit flush counter saturates at 15.
        doReset();
        branchTaken = 1; branchTarget = 32'h80;
        for (int i = 0; i < 20; i++) begin
            #1;
            chk($sformatf("sat%0d.flushCnt", i), 32'(cFlushCnt), (i > 15) ? 32'd15 : 32'(i));
            chk($sformatf("sat%0d.br", i), 32'(cBr), 32'd1);
            tick();
        end
        chk("sat.final", 32'(cFlushCnt), 32'd15);
        chk("sat.addr", cAddr, 32'h80);
        chk("sat.stall", 32'(cStall), 32'd0);
        chk("sat.bubble", 32'(cBub), 32'd0);
        chk("sat.stallCnt", 32'(cStallCnt), 32'd0);
        branchTaken = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
